// File: rtl/sync_stream_rx.sv
// Raster stream receiver: turns VSYNC/HSYNC-qualified pixels into a linearly
// addressed pixel stream and enforces frame geometry before layer 0.
module sync_stream_rx #(
    parameter int  dataWidth  = 12,
    parameter int  img_width  = 64,
    parameter int  img_height = 64,
    localparam int ADDR_W     = $clog2(img_width * img_height),
    localparam int X_W        = $clog2(img_width + 1),
    localparam int L_W        = $clog2(img_height + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [dataWidth-1:0] in,
    input  logic                 HSYNC,
    input  logic                 VSYNC,
    output logic [dataWidth-1:0] pix_out,
    output logic                 pix_valid,
    output logic [ADDR_W-1:0]    pix_addr,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [3:0]           err_code
);

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_ARMED    = 2'd1,
        S_FRAME    = 2'd2
    } state_t;

    localparam logic [X_W-1:0]    X_MAX = X_W'(img_width);
    localparam logic [X_W-1:0]    X_ONE = X_W'(1);
    localparam logic [L_W-1:0]    L_MAX = L_W'(img_height);
    localparam logic [L_W-1:0]    L_ONE = L_W'(1);
    localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(img_width * img_height - 1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_vs_q;
    logic                   r_hs_q;
    logic [X_W-1:0]         r_x;
    logic [X_W-1:0]         w_x_cur;
    logic [X_W-1:0]         w_x_nxt;
    logic [L_W-1:0]         r_line;
    logic [L_W-1:0]         w_line_cur;
    logic [L_W-1:0]         w_line_nxt;
    logic [L_W-1:0]         w_le_line;
    logic [L_W-1:0]         w_line_fin;
    logic [ADDR_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]      w_cnt_cur;
    logic [ADDR_W-1:0]      w_cnt_nxt;
    logic [3:0]             r_err;
    logic [3:0]             w_err_cur;
    logic [3:0]             w_err_nxt;
    logic [3:0]             w_err_fin;
    logic                   w_vs_rise;
    logic                   w_start;
    logic                   w_active;
    logic                   w_le_short;
    logic                   w_emit;
    logic                   w_done;
    logic                   w_ok;
    logic [dataWidth-1:0]   r_pix_out;
    logic                   r_pix_valid;
    logic [ADDR_W-1:0]      r_pix_addr;
    logic                   r_frame_start;
    logic                   r_frame_done;
    logic                   r_frame_ok;

    assign w_vs_rise  = VSYNC & ~r_vs_q;
    assign w_start    = (r_state == S_ARMED) & w_vs_rise;
    assign w_active   = w_start | ((r_state == S_FRAME) & VSYNC);

    // The frame-start cycle works on freshly cleared counters so a pixel
    // present on the VSYNC rise is accepted at address 0.
    assign w_x_cur    = w_start ? '0 : r_x;
    assign w_line_cur = w_start ? '0 : r_line;
    assign w_cnt_cur  = w_start ? '0 : r_cnt;
    assign w_err_cur  = w_start ? 4'b0000 : r_err;

    assign w_le_short = (r_x != X_MAX) && (r_line < L_MAX);
    assign w_le_line  = (r_line == L_MAX) ? r_line : r_line + L_ONE;
    assign w_line_fin = r_hs_q ? w_le_line : r_line;
    assign w_err_fin  = r_err | {(w_line_fin < L_MAX), 2'b00, (r_hs_q & w_le_short)};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_LOW: begin
                if (!VSYNC) begin
                    w_state_nxt = S_ARMED;
                end else begin
                    w_state_nxt = S_WAIT_LOW;
                end
            end
            S_ARMED: begin
                if (w_vs_rise) begin
                    w_state_nxt = S_FRAME;
                end else begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_FRAME: begin
                if (!VSYNC) begin
                    w_state_nxt = S_ARMED;
                end else begin
                    w_state_nxt = S_FRAME;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOW;
            end
        endcase
    end

    // Pixel acceptance, line-end and frame-end rules
    always_comb begin
        w_x_nxt    = r_x;
        w_line_nxt = r_line;
        w_cnt_nxt  = r_cnt;
        w_err_nxt  = r_err;
        w_emit     = 1'b0;
        w_done     = 1'b0;
        w_ok       = 1'b0;
        if (w_active) begin
            w_x_nxt    = w_x_cur;
            w_line_nxt = w_line_cur;
            w_cnt_nxt  = w_cnt_cur;
            w_err_nxt  = w_err_cur;
            if (HSYNC) begin
                if (w_line_cur == L_MAX) begin
                    w_err_nxt = w_err_cur | 4'b0100;
                end else if (w_x_cur == X_MAX) begin
                    w_err_nxt = w_err_cur | 4'b0010;
                end else begin
                    w_emit    = 1'b1;
                    w_x_nxt   = w_x_cur + X_ONE;
                    w_cnt_nxt = (w_cnt_cur == A_MAX) ? w_cnt_cur : w_cnt_cur + A_ONE;
                end
            end else if (r_hs_q && !w_start) begin
                w_x_nxt    = '0;
                w_line_nxt = w_le_line;
                w_err_nxt  = r_err | {3'b000, w_le_short};
            end else begin
                w_x_nxt = w_x_cur;
            end
        end else if (r_state == S_FRAME) begin
            // VSYNC dropped: close any open line, then judge the frame.
            w_x_nxt    = '0;
            w_line_nxt = w_line_fin;
            w_err_nxt  = w_err_fin;
            w_done     = 1'b1;
            w_ok       = (w_err_fin == 4'b0000);
        end else begin
            w_done = 1'b0;
        end
    end

    // Sync sampling, frame counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q        <= 1'b0;
            r_hs_q        <= 1'b0;
            r_x           <= '0;
            r_line        <= '0;
            r_cnt         <= '0;
            r_err         <= 4'b0000;
            r_pix_out     <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_addr    <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
        end else begin
            r_vs_q        <= VSYNC;
            r_hs_q        <= HSYNC;
            r_x           <= w_x_nxt;
            r_line        <= w_line_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err         <= w_err_nxt;
            r_pix_valid   <= w_emit;
            r_frame_start <= w_start;
            r_frame_done  <= w_done;
            r_frame_ok    <= w_ok;
            if (w_emit) begin
                r_pix_out  <= in;
                r_pix_addr <= w_cnt_cur;
            end
        end
    end

    assign pix_out     = r_pix_out;
    assign pix_valid   = r_pix_valid;
    assign pix_addr    = r_pix_addr;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_ok    = r_frame_ok;
    assign err_code    = r_err;

endmodule

// File: tb/tb_sync_stream_rx.sv
// Bench for sync_stream_rx: frames are generated from a geometry description
// and the expected pixel/start/done events are derived from that geometry.
module tb_sync_stream_rx;
    localparam int DW = 12;
    localparam int W  = 64;
    localparam int H  = 64;
    localparam int AW = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_px = '0;
    logic          hs    = 1'b0;
    logic          vs    = 1'b0;
    logic [DW-1:0] pix_out;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic          frame_start;
    logic          frame_done;
    logic          frame_ok;
    logic [3:0]    err_code;

    sync_stream_rx #(.dataWidth(DW), .img_width(W), .img_height(H)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_px), .HSYNC(hs), .VSYNC(vs),
        .pix_out(pix_out), .pix_valid(pix_valid), .pix_addr(pix_addr),
        .frame_start(frame_start), .frame_done(frame_done),
        .frame_ok(frame_ok), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [DW-1:0] d; logic [AW-1:0] a; } pix_t;
    typedef struct { int cyc; bit ok; logic [3:0] err; } done_t;

    pix_t  pq[$];
    done_t dq[$];
    int    sq[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_pix    = 0;
    int    n_done   = 0;
    bit    last_ok  = 1'b0;
    logic [3:0] last_err = 4'b0000;
    bit    seen_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the expected event queues
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {pix_valid, frame_start, frame_done, frame_ok,
                                    err_code, pix_out, pix_addr}, 32'd0);
        end else begin
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                check("pix_valid", {31'd0, pix_valid}, 32'd1);
                check("pix_out", {20'd0, pix_out}, {20'd0, pq[0].d});
                check("pix_addr", {20'd0, pix_addr}, {20'd0, pq[0].a});
                void'(pq.pop_front());
            end else begin
                check("pix_idle", {31'd0, pix_valid}, 32'd0);
            end
            if (pix_valid) n_pix++;
            if (sq.size() > 0 && sq[0] == cyc) begin
                check("frame_start", {31'd0, frame_start}, 32'd1);
                void'(sq.pop_front());
            end else begin
                check("start_idle", {31'd0, frame_start}, 32'd0);
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                check("frame_done", {31'd0, frame_done}, 32'd1);
                check("frame_ok", {31'd0, frame_ok}, {31'd0, dq[0].ok});
                check("err_code", {28'd0, err_code}, {28'd0, dq[0].err});
                void'(dq.pop_front());
            end else begin
                check("done_idle", {31'd0, frame_done}, 32'd0);
            end
            if (frame_done) begin
                n_done++;
                last_ok  = frame_ok;
                last_err = err_code;
            end
            check("valid_with_done", {31'd0, pix_valid & frame_done}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        rst_n = 1'b0;
        #1;
        check("async_reset", {pix_valid, frame_start, frame_done, frame_ok,
                              err_code, pix_out, pix_addr}, 32'd0);
        pq.delete();
        dq.delete();
        sq.delete();
        seen_low = 1'b0;
        hs = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // One frame: nlines lines of W pixels, except short_ln (W-1) and long_ln (W+1).
    task automatic drive_frame(input int nlines, input int short_ln, input int long_ln,
                               input int lead, input int hgap, input int last_gap,
                               input int vgap, input bit addr_data, input int abort_at);
        bit         cap;
        int         emit;
        int         len;
        logic [3:0] err;
        logic [DW-1:0] d;
        pix_t       p;
        done_t      dn;
        cap  = seen_low;
        emit = 0;
        err  = 4'b0000;
        vs   = 1'b1;
        if (cap) sq.push_back(cyc + 1);
        for (int k = 0; k < lead; k++) begin
            hs = 1'b0;
            step();
        end
        for (int i = 0; i < nlines; i++) begin
            len = W;
            if (i == short_ln) len = W - 1;
            else if (i == long_ln) len = W + 1;
            for (int j = 0; j < len; j++) begin
                if (abort_at >= 0 && emit == abort_at) begin
                    do_abort();
                    return;
                end
                d     = addr_data ? DW'(emit) : DW'($urandom);
                hs    = 1'b1;
                in_px = d;
                if (i >= H) begin
                    err[2] = 1'b1;
                end else if (j >= W) begin
                    err[1] = 1'b1;
                end else begin
                    if (cap) begin
                        p.cyc = cyc + 1;
                        p.d   = d;
                        p.a   = AW'(emit);
                        pq.push_back(p);
                    end
                    emit++;
                end
                step();
            end
            if (i < H && len < W) err[0] = 1'b1;
            hs = 1'b0;
            if (i != nlines - 1) repeat (hgap) step();
            else repeat (last_gap) step();
        end
        if (nlines < H) err[3] = 1'b1;
        vs = 1'b0;
        hs = 1'($urandom_range(0, 1));
        if (cap) begin
            dn.cyc = cyc + 1;
            dn.ok  = (err == 4'b0000);
            dn.err = err;
            dq.push_back(dn);
        end
        seen_low = 1'b1;
        repeat (vgap) step();
    endtask

    initial begin
        int nl;
        int sl;
        int ll;
        // Start-up while a frame is already streaming: nothing may be captured.
        rst_n = 1'b0;
        vs    = 1'b1;
        hs    = 1'b1;
        repeat (4) step();
        rst_n = 1'b1;
        n_pix = 0;
        repeat (10) begin
            in_px = DW'($urandom);
            step();
        end
        hs = 1'b0;
        repeat (4) step();
        drive_frame(4, -1, -1, 0, 1, 1, 1, 1'b0, -1);
        step();
        check("startup_no_pix", n_pix, 32'd0);
        check("startup_no_done", n_done, 32'd0);

        // Nominal frame with pixel value = address.
        n_pix  = 0;
        n_done = 0;
        drive_frame(64, -1, -1, 3, 4, 4, 1, 1'b1, -1);
        step();
        check("nominal_pix_count", n_pix, 32'd4096);
        check("nominal_done_count", n_done, 32'd1);
        check("nominal_ok", {31'd0, last_ok}, 32'd1);
        check("nominal_err", {28'd0, last_err}, 32'd0);

        // Ten back-to-back frames with a single-cycle VSYNC gap.
        n_pix  = 0;
        n_done = 0;
        repeat (10) drive_frame(64, -1, -1, 3, 1, 1, 1, 1'b0, -1);
        step();
        check("b2b_done_count", n_done, 32'd10);
        check("b2b_pix_count", n_pix, 32'd40960);
        check("b2b_last_ok", {31'd0, last_ok}, 32'd1);

        // Short line 5 and long line 9.
        n_pix = 0;
        drive_frame(64, 5, 9, 3, 2, 2, 1, 1'b0, -1);
        step();
        check("shortlong_pix_count", n_pix, 32'd4095);
        check("shortlong_err", {28'd0, last_err}, 32'h3);
        check("shortlong_ok", {31'd0, last_ok}, 32'd0);

        // Too few and too many lines.
        n_pix = 0;
        drive_frame(63, -1, -1, 2, 1, 3, 1, 1'b0, -1);
        step();
        check("few_lines_pix_count", n_pix, 32'd4032);
        check("few_lines_err", {28'd0, last_err}, 32'h8);
        n_pix = 0;
        drive_frame(65, -1, -1, 1, 1, 2, 1, 1'b0, -1);
        step();
        check("many_lines_pix_count", n_pix, 32'd4096);
        check("many_lines_err", {28'd0, last_err}, 32'h4);

        // HSYNC high on the VSYNC rise and HSYNC/VSYNC falling together.
        n_done = 0;
        drive_frame(64, -1, -1, 0, 1, 0, 2, 1'b0, -1);
        step();
        check("edge_done_count", n_done, 32'd1);
        check("edge_ok", {31'd0, last_ok}, 32'd1);

        // Reset at pixel 1000, then recover on the next full frame.
        n_done = 0;
        drive_frame(64, -1, -1, 3, 1, 1, 1, 1'b0, 1000);
        drive_frame(4, -1, -1, 0, 1, 1, 1, 1'b0, -1);
        check("abort_no_done", n_done, 32'd0);
        drive_frame(64, -1, -1, 3, 1, 1, 1, 1'b1, -1);
        step();
        check("recover_done_count", n_done, 32'd1);
        check("recover_ok", {31'd0, last_ok}, 32'd1);

        // Randomized geometry.
        repeat (2) begin
            nl = 63 + int'($urandom_range(0, 2));
            sl = -1;
            ll = -1;
            if ($urandom_range(0, 1) == 1) sl = int'($urandom_range(0, 62));
            if ($urandom_range(0, 1) == 1) ll = int'($urandom_range(0, 62));
            drive_frame(nl, sl, ll, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b0, -1);
        end
        repeat (3) step();
        check("queues_drained", pq.size() + dq.size() + sq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
